// File: rtl/key_matrix_if.sv
// Keypad-side signal bundle for key_matrix_scan: matrix drive/sense, clear, and key event outputs.
interface key_matrix_if;
    logic [3:0]  i_col;
    logic        i_clr;
    logic [3:0]  o_row;
    logic        o_key_valid;
    logic [3:0]  o_key_code;
    logic        o_key_down;
    logic [31:0] o_digits;

    modport master (
        output i_col, i_clr,
        input  o_row, o_key_valid, o_key_code, o_key_down, o_digits
    );

    modport slave (
        input  i_col, i_clr,
        output o_row, o_key_valid, o_key_code, o_key_down, o_digits
    );
endinterface

// File: rtl/key_matrix_scan.sv
// 4x4 hex keypad scanner: row strobing, whole-frame debounce, press FSM and a 32-bit digit shift register.
// Define KEY_REPEAT_EN to add auto-repeat events every REPEAT_FRMS accepted frames while a key is held.
module key_matrix_scan #(
    parameter int SCAN_DIV_W    = 15,
    parameter int DEBOUNCE_FRMS = 4,
    parameter int REPEAT_FRMS   = 64
) (
    input  logic         clk,
    input  logic         rstn,
    key_matrix_if.slave  kp
);
    typedef enum logic [1:0] {ST_IDLE, ST_PRESSED, ST_JAM} state_e;

    localparam logic [3:0] DEB_N = 4'(DEBOUNCE_FRMS);

    logic [3:0]            col_s1_q, col_s2_q;
    logic [SCAN_DIV_W-1:0] presc_q, presc_d;
    logic [1:0]            row_q, row_d;
    logic [15:0]           snap_q, snap_d;
    logic [15:0]           prev_q, prev_d;
    logic [3:0]            deb_cnt_q, deb_cnt_d;
    logic                  acc_vld_q, acc_vld_d;
    logic [15:0]           acc_q, acc_d;
    logic [15:0]           held_q, held_d;
    state_e                state_q, state_d;
    logic                  valid_q, valid_d;
    logic [3:0]            code_q, code_d;
    logic [31:0]           digits_q, digits_d;

    logic                  tick;
    logic [3:0]            cols;
    logic [15:0]           frame;
    logic                  one_hot;
    logic [3:0]            enc;
    logic                  fire;

`ifdef KEY_REPEAT_EN
    localparam int REP_W = (REPEAT_FRMS > 1) ? $clog2(REPEAT_FRMS) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_FRMS - 1);
    logic [REP_W-1:0] rep_q, rep_d;
`else
    logic unused_repeat;
    assign unused_repeat = (REPEAT_FRMS > 0);
`endif

    assign tick  = &presc_q;
    assign cols  = ~col_s2_q;
    // The row being sampled on a row-3 tick is still in the synchronizer, not yet in snap_q.
    assign frame = {cols, snap_q[11:0]};

    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    always_comb begin
        presc_d   = presc_q + 1'b1;
        row_d     = row_q;
        snap_d    = snap_q;
        prev_d    = prev_q;
        deb_cnt_d = deb_cnt_q;
        acc_vld_d = 1'b0;
        acc_d     = acc_q;
        if (tick) begin
            snap_d[{row_q, 2'b00} +: 4] = cols;
            row_d = row_q + 2'd1;
            if (row_q == 2'd3) begin
                prev_d = frame;
                if (frame == prev_q) begin
                    if (deb_cnt_q != DEB_N) deb_cnt_d = deb_cnt_q + 4'd1;
                end else begin
                    deb_cnt_d = 4'd1;
                end
                if (deb_cnt_d == DEB_N) begin
                    acc_vld_d = 1'b1;
                    acc_d     = frame;
                end
            end
        end
    end

    assign one_hot = (acc_q != 16'h0) && ((acc_q & (acc_q - 16'd1)) == 16'h0);

    always_comb begin
        enc = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (acc_q[i]) enc = 4'(i);
        end
    end

    always_comb begin
        state_d  = state_q;
        held_d   = held_q;
        valid_d  = 1'b0;
        code_d   = code_q;
        digits_d = digits_q;
        fire     = 1'b0;
`ifdef KEY_REPEAT_EN
        rep_d    = rep_q;
`endif
        if (acc_vld_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (one_hot) begin
                        state_d = ST_PRESSED;
                        held_d  = acc_q;
                        code_d  = enc;
                        fire    = 1'b1;
`ifdef KEY_REPEAT_EN
                        rep_d   = '0;
`endif
                    end else if (acc_q != 16'h0) begin
                        state_d = ST_JAM;
                    end
                end
                ST_PRESSED: begin
                    if (acc_q == held_q) begin
`ifdef KEY_REPEAT_EN
                        if (rep_q == REP_LAST) begin
                            fire  = 1'b1;
                            rep_d = '0;
                        end else begin
                            rep_d = rep_q + 1'b1;
                        end
`endif
                    end else begin
                        state_d = (acc_q == 16'h0) ? ST_IDLE : ST_JAM;
`ifdef KEY_REPEAT_EN
                        rep_d   = '0;
`endif
                    end
                end
                ST_JAM: begin
                    if (acc_q == 16'h0) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
        valid_d = fire;
        // A clear landing on an event edge still keeps the key just entered.
        if (kp.i_clr) begin
            digits_d = fire ? {28'h0, code_d} : 32'h0;
        end else if (fire) begin
            digits_d = {digits_q[27:0], code_d};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: the frame registers (snap/prev/acc/held) are reset too, so a mid-press reset leaves no stale frame behind.
        if (!rstn) begin
            col_s1_q  <= 4'hF;
            col_s2_q  <= 4'hF;
            presc_q   <= '0;
            row_q     <= 2'd0;
            snap_q    <= 16'h0;
            prev_q    <= 16'h0;
            deb_cnt_q <= 4'd0;
            acc_vld_q <= 1'b0;
            acc_q     <= 16'h0;
            held_q    <= 16'h0;
            state_q   <= ST_IDLE;
            valid_q   <= 1'b0;
            code_q    <= 4'h0;
            digits_q  <= 32'h0;
`ifdef KEY_REPEAT_EN
            rep_q     <= '0;
`endif
        end else begin
            col_s1_q  <= kp.i_col;
            col_s2_q  <= col_s1_q;
            presc_q   <= presc_d;
            row_q     <= row_d;
            snap_q    <= snap_d;
            prev_q    <= prev_d;
            deb_cnt_q <= deb_cnt_d;
            acc_vld_q <= acc_vld_d;
            acc_q     <= acc_d;
            held_q    <= held_d;
            state_q   <= state_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
            digits_q  <= digits_d;
`ifdef KEY_REPEAT_EN
            rep_q     <= rep_d;
`endif
        end
    end

    assign kp.o_row       = ~(4'b0001 << row_q);
    assign kp.o_key_valid = valid_q;
    assign kp.o_key_code  = code_q;
    assign kp.o_key_down  = (state_q == ST_PRESSED);
    assign kp.o_digits    = digits_q;
endmodule

// File: tb/tb_key_matrix_scan.sv
// Self-checking bench for key_matrix_scan: a frame-level keypad model checked every cycle plus directed literal checks.
module tb_key_matrix_scan;
    localparam int DIV_W     = 4;
    localparam int DEB       = 4;
    localparam int REP       = 8;
    localparam int ROW_CYC   = 16;
    localparam int FRAME_CYC = 64;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] keys = 16'h0;
    int          checks = 0;
    int          failures = 0;
    int          ev_count = 0;
    logic [3:0]  ev_code = 4'h0;
    int          ev0;

    key_matrix_if kp();

    key_matrix_scan #(
        .SCAN_DIV_W   (DIV_W),
        .DEBOUNCE_FRMS(DEB),
        .REPEAT_FRMS  (REP)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .kp  (kp.slave)
    );

    always #5 clk = ~clk;

    // A closed key on the driven (low) row pulls its column low.
    always_comb begin
        kp.i_col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!kp.o_row[r] && keys[r*4+c]) kp.i_col[c] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] code_of(input logic [15:0] f);
        code_of = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (f[i]) code_of = 4'(i);
        end
    endfunction

    // ---------------- frame-level reference model ----------------
    logic [15:0] m_snap, m_prev, m_last, m_frame;
    int          m_cnt, m_state, m_rep, row_cyc, m_r;
    logic [3:0]  m_code, m_prev_row, pend_code;
    logic [31:0] m_digits;
    logic        m_down, pend_evt, pend_apply, clr_at_edge;

    always @(posedge clk) clr_at_edge <= kp.i_clr;

    always @(negedge clk) begin
        if (!rstn) begin
            m_snap = 16'h0; m_prev = 16'h0; m_last = 16'h0;
            m_cnt = 0; m_state = 0; m_rep = 0; row_cyc = 0;
            m_code = 4'h0; m_prev_row = 4'b1110; m_digits = 32'h0;
            m_down = 1'b0; pend_evt = 1'b0; pend_apply = 1'b0; pend_code = 4'h0;
        end else begin
            row_cyc++;
            // Results of the frame decided at the previous negedge become visible now.
            check("key_valid", {31'h0, kp.o_key_valid}, {31'h0, pend_evt});
            if (pend_evt) begin
                m_code   = pend_code;
                m_digits = clr_at_edge ? {28'h0, pend_code} : {m_digits[27:0], pend_code};
            end else if (clr_at_edge) begin
                m_digits = 32'h0;
            end
            if (pend_apply) m_down = (m_state == 1);
            pend_evt   = 1'b0;
            pend_apply = 1'b0;
            check("key_code", {28'h0, kp.o_key_code}, {28'h0, m_code});
            check("digits", kp.o_digits, m_digits);
            check("key_down", {31'h0, kp.o_key_down}, {31'h0, m_down});
            check("row_onehot", $countones(~kp.o_row), 32'd1);
            if (kp.o_row != m_prev_row) begin
                check("row_period", row_cyc, ROW_CYC);
                check("row_order", {28'h0, kp.o_row}, {28'h0, m_prev_row[2:0], m_prev_row[3]});
                row_cyc = 0;
                m_r = 0;
                for (int i = 0; i < 4; i++) if (!m_prev_row[i]) m_r = i;
                m_snap[m_r*4 +: 4] = keys[m_r*4 +: 4];
                m_prev_row = kp.o_row;
                if (m_r == 3) begin
                    m_frame = m_snap;
                    if (m_frame == m_prev) m_cnt = (m_cnt < DEB) ? m_cnt + 1 : DEB;
                    else m_cnt = 1;
                    m_prev = m_frame;
                    if (m_cnt == DEB) begin
                        pend_apply = 1'b1;
                        case (m_state)
                            0: if (m_frame != 16'h0) begin
                                if ($countones(m_frame) == 1) begin
                                    m_state = 1; m_rep = 0;
                                    pend_evt = 1'b1; pend_code = code_of(m_frame);
                                end else begin
                                    m_state = 2;
                                end
                            end
                            1: if (m_frame == m_last) begin
`ifdef KEY_REPEAT_EN
                                m_rep++;
                                if (m_rep == REP) begin
                                    m_rep = 0; pend_evt = 1'b1; pend_code = code_of(m_frame);
                                end
`endif
                            end else begin
                                m_state = (m_frame == 16'h0) ? 0 : 2;
                            end
                            default: if (m_frame == 16'h0) m_state = 0;
                        endcase
                        m_last = m_frame;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rstn && kp.o_key_valid) begin
            ev_count++;
            ev_code = kp.o_key_code;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_frame_start();
        logic [3:0] prev;
        for (int g = 0; g < 4 * FRAME_CYC; g++) begin
            prev = kp.o_row;
            @(negedge clk);
            if (kp.o_row == 4'b1110 && prev != 4'b1110) return;
        end
        checks++;
        failures++;
        $display("FAIL frame_start_timeout: got no row-0 start within %0d cycles", 4 * FRAME_CYC);
    endtask

    // Mid-row-0 alignment keeps every key change well away from a sampling tick.
    task automatic align();
        wait_frame_start();
        cycles(8);
    endtask

    task automatic tap(input int k, input int hold_frms, input int rel_frms);
        align();
        keys = 16'h0;
        keys[k] = 1'b1;
        cycles(hold_frms * FRAME_CYC);
        keys = 16'h0;
        cycles(rel_frms * FRAME_CYC);
    endtask

    initial begin
        kp.i_clr = 1'b0;
        cycles(3);
        check("rst_row", {28'h0, kp.o_row}, 32'hE);
        check("rst_valid", {31'h0, kp.o_key_valid}, 32'h0);
        check("rst_code", {28'h0, kp.o_key_code}, 32'h0);
        check("rst_down", {31'h0, kp.o_key_down}, 32'h0);
        check("rst_digits", kp.o_digits, 32'h0);
        @(negedge clk);
        #1 rstn = 1'b1;

        // Idle scanning.
        cycles(12 * FRAME_CYC);
        check("idle_events", ev_count, 32'd0);
        check("idle_digits", kp.o_digits, 32'h0);

        // Clean press of row2/col1, then release.
        ev0 = ev_count;
        align();
        keys[9] = 1'b1;
        cycles(6 * FRAME_CYC);
        check("press9_down", {31'h0, kp.o_key_down}, 32'h1);
        keys = 16'h0;
        cycles(3 * FRAME_CYC);
        check("release9_down_held", {31'h0, kp.o_key_down}, 32'h1);
        cycles(FRAME_CYC + 8);
        check("release9_down_low", {31'h0, kp.o_key_down}, 32'h0);
        cycles(FRAME_CYC);
        check("press9_events", ev_count - ev0, 32'd1);
        check("press9_code", {28'h0, ev_code}, 32'h9);
        check("press9_digits", kp.o_digits, 32'h9);

        // Bouncy press of 4'h6.
        ev0 = ev_count;
        align();
        keys[6] = 1'b1; cycles(16);
        keys = 16'h0;   cycles(32);
        keys[6] = 1'b1; cycles(32);
        keys = 16'h0;   cycles(32);
        keys[6] = 1'b1; cycles(6 * FRAME_CYC);
        keys = 16'h0;   cycles(6 * FRAME_CYC);
        check("bounce_events", ev_count - ev0, 32'd1);
        check("bounce_code", {28'h0, ev_code}, 32'h6);

        // Too-short press.
        ev0 = ev_count;
        tap(3, 3, 6);
        check("short_events", ev_count - ev0, 32'd0);

        // Two keys together jam, then a clean 4'hA.
        ev0 = ev_count;
        align();
        keys[1] = 1'b1; keys[5] = 1'b1;
        cycles(6 * FRAME_CYC);
        check("jam_down", {31'h0, kp.o_key_down}, 32'h0);
        keys = 16'h0;
        cycles(6 * FRAME_CYC);
        check("jam_events", ev_count - ev0, 32'd0);
        tap(10, 6, 6);
        check("after_jam_events", ev_count - ev0, 32'd1);
        check("after_jam_code", {28'h0, ev_code}, 32'hA);

        // Clear, then enter 1..9.
        @(negedge clk); kp.i_clr = 1'b1;
        @(negedge clk); kp.i_clr = 1'b0;
        @(negedge clk);
        check("clr_digits", kp.o_digits, 32'h0);
        for (int k = 1; k <= 9; k++) tap(k, 5, 5);
        check("seq_digits", kp.o_digits, 32'h23456789);

        // Clear coinciding with the event of 4'hC.
        align();
        keys[12] = 1'b1;
        repeat (4) wait_frame_start();
        kp.i_clr = 1'b1;
        @(negedge clk);
        kp.i_clr = 1'b0;
        check("clr_evt_pulse", {31'h0, kp.o_key_valid}, 32'h1);
        check("clr_evt_digits", kp.o_digits, 32'h0000000C);
        cycles(6);
        keys = 16'h0;
        cycles(6 * FRAME_CYC);
        check("clr_evt_digits_hold", kp.o_digits, 32'h0000000C);

        // Long hold of 4'h7: 30 accepted frames.
        ev0 = ev_count;
        tap(7, 33, 6);
`ifdef KEY_REPEAT_EN
        check("hold7_events", ev_count - ev0, 32'd4);
`else
        check("hold7_events", ev_count - ev0, 32'd1);
`endif
        check("hold7_code", {28'h0, ev_code}, 32'h7);

        // Reset in the middle of a press.
        align();
        keys[3] = 1'b1;
        cycles(6 * FRAME_CYC);
        check("pre_rst_down", {31'h0, kp.o_key_down}, 32'h1);
        #1 rstn = 1'b0;
        #1;
        check("midrst_row", {28'h0, kp.o_row}, 32'hE);
        check("midrst_valid", {31'h0, kp.o_key_valid}, 32'h0);
        check("midrst_code", {28'h0, kp.o_key_code}, 32'h0);
        check("midrst_down", {31'h0, kp.o_key_down}, 32'h0);
        check("midrst_digits", kp.o_digits, 32'h0);
        keys = 16'h0;
        cycles(3);
        @(negedge clk);
        #1 rstn = 1'b1;
        ev0 = ev_count;
        cycles(8 * FRAME_CYC);
        check("post_rst_events", ev_count - ev0, 32'd0);
        check("post_rst_digits", kp.o_digits, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
